// File: rtl/uart_rx_pkt_ctrl.sv
// UART receive packet controller: acknowledges receiver bytes, frames SYNC/LEN/payload/CHK
// packets, buffers one payload and streams it to the consumer over valid/ready.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         TMO_W       = 16
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       rx_rdy_clr,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_last,
    input  logic       m_ready,
    output logic       pkt_ok,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_tmo,
    output logic       drop_ovf,
    output logic       busy
);
    localparam int               PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

    state_t           state;
    logic             rx_rdy_q;
    logic [7:0]       len;
    logic [7:0]       chk;
    logic [7:0]       wr_ptr;
    logic [7:0]       rd_ptr;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       pkt_buf [MAX_LEN];

    logic       take;
    logic       len_ok;
    logic       buf_we;
    logic       in_frame;
    logic [7:0] rd_nxt;

    // A byte is taken once per rising edge of rx_rdy, so a level held high is acknowledged once.
    assign take     = rx_rdy & ~rx_rdy_q;
    assign len_ok   = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);
    assign buf_we   = take && (state == S_PAYLOAD);
    assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    assign rd_nxt   = rd_ptr + 8'd1;

    // NOTE: the payload buffer is deliberately not reset; the FSM never reads an entry it has
    // not written in the current packet, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk_50m) begin
        if (buf_we) begin
            pkt_buf[wr_ptr[PTR_W-1:0]] <= rx_data;
        end
    end

    // NOTE: every register here uses <= so all reads see pre-edge values regardless of order.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state      <= S_HUNT;
            rx_rdy_q   <= 1'b0;
            len        <= '0;
            chk        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tmo_cnt    <= '0;
            rx_rdy_clr <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            pkt_ok     <= 1'b0;
            err_chk    <= 1'b0;
            err_len    <= 1'b0;
            err_tmo    <= 1'b0;
            drop_ovf   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_rdy_q   <= rx_rdy;
            rx_rdy_clr <= take;
            pkt_ok     <= 1'b0;
            err_chk    <= 1'b0;
            err_len    <= 1'b0;
            err_tmo    <= 1'b0;
            drop_ovf   <= 1'b0;

            // Inter-byte watchdog; a take in the expiry cycle wins over the timeout.
            if (!in_frame || take) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
                tmo_cnt <= '0;
                err_tmo <= 1'b1;
                state   <= S_HUNT;
                busy    <= 1'b0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                S_HUNT: begin
                    if (take && rx_data == SYNC_BYTE) begin
                        state <= S_LEN;
                        busy  <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (take) begin
                        if (len_ok) begin
                            len    <= rx_data;
                            chk    <= rx_data;
                            wr_ptr <= '0;
                            state  <= S_PAYLOAD;
                        end else begin
                            err_len <= 1'b1;
                            state   <= S_HUNT;
                            busy    <= 1'b0;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (take) begin
                        chk    <= chk ^ rx_data;
                        wr_ptr <= wr_ptr + 8'd1;
                        if (wr_ptr == len - 8'd1) begin
                            state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (take) begin
                        if (rx_data == chk) begin
                            pkt_ok  <= 1'b1;
                            rd_ptr  <= '0;
                            m_valid <= 1'b1;
                            m_data  <= pkt_buf[0];
                            m_last  <= (len == 8'd1);
                            state   <= S_DRAIN;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= S_HUNT;
                            busy    <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Bytes arriving while the buffer drains are acknowledged but discarded.
                    if (take) begin
                        drop_ovf <= 1'b1;
                    end
                    if (m_valid && m_ready) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            state   <= S_HUNT;
                            busy    <= 1'b0;
                        end else begin
                            rd_ptr <= rd_nxt;
                            m_data <= pkt_buf[rd_nxt[PTR_W-1:0]];
                            m_last <= (rd_nxt == len - 8'd1);
                        end
                    end
                end
                default: begin
                    state <= S_HUNT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: framing, checksum, length, timeout, backpressure and
// reset cases with hand-computed expectations.
module tb_uart_rx_pkt_ctrl;

    logic       clk_50m;
    logic       rst;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_rdy_clr;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;
    logic       pkt_ok;
    logic       err_chk;
    logic       err_len;
    logic       err_tmo;
    logic       drop_ovf;
    logic       busy;

    uart_rx_pkt_ctrl #(
        .SYNC_BYTE  (8'hA5),
        .MAX_LEN    (16),
        .TIMEOUT_CYC(8),
        .TMO_W      (16)
    ) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .rx_rdy_clr(rx_rdy_clr),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .pkt_ok    (pkt_ok),
        .err_chk   (err_chk),
        .err_len   (err_len),
        .err_tmo   (err_tmo),
        .drop_ovf  (drop_ovf),
        .busy      (busy)
    );

    initial begin
        clk_50m = 1'b0;
        forever #10 clk_50m = ~clk_50m;
    end

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } beat_t;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    take_cyc = 0;
    int    tmo_cyc  = 0;
    logic  rdy_prev = 1'b0;
    int    cnt_clr = 0, cnt_pkt = 0, cnt_chk = 0, cnt_len = 0, cnt_tmo = 0;
    int    cnt_drop = 0, cnt_mvalid = 0, cnt_multi = 0;
    beat_t beats[$];
    beat_t mon_b;
    int    mv_snap;

    // Pulse and handshake monitor; inputs only change on the falling edge.
    always @(posedge clk_50m) begin
        cyc      <= cyc + 1;
        rdy_prev <= rx_rdy;
        if (rx_rdy && !rdy_prev) take_cyc <= cyc;
        if (rx_rdy_clr) cnt_clr <= cnt_clr + 1;
        if (pkt_ok)     cnt_pkt <= cnt_pkt + 1;
        if (err_chk)    cnt_chk <= cnt_chk + 1;
        if (err_len)    cnt_len <= cnt_len + 1;
        if (err_tmo) begin
            cnt_tmo <= cnt_tmo + 1;
            tmo_cyc <= cyc - 1;
        end
        if (drop_ovf) cnt_drop <= cnt_drop + 1;
        if (m_valid)  cnt_mvalid <= cnt_mvalid + 1;
        if ((32'(err_chk) + 32'(err_len) + 32'(err_tmo)) > 1) cnt_multi <= cnt_multi + 1;
        if (m_valid && m_ready) begin
            mon_b.data = m_data;
            mon_b.last = m_last;
            mon_b.cyc  = cyc;
            beats.push_back(mon_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk_50m);
        check("rx_rdy_clr after take", 32'(rx_rdy_clr), 1);
        rx_rdy = 1'b0;
        @(negedge clk_50m);
    endtask

    task automatic check_beat(input int idx, input logic [7:0] data, input logic last);
        if (idx < beats.size()) begin
            check($sformatf("beat%0d data", idx), 32'(beats[idx].data), 32'(data));
            check($sformatf("beat%0d last", idx), 32'(beats[idx].last), 32'(last));
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {17'd0, busy, m_valid, m_last, rx_rdy_clr, pkt_ok,
                err_chk, err_len, err_tmo, drop_ovf, m_data};
    endfunction

    initial begin
        rst     = 1'b1;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        m_ready = 1'b1;
        repeat (3) @(negedge clk_50m);
        check("reset outputs", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk_50m);
        check("idle busy", 32'(busy), 0);

        // Good packet; XOR of 03,11,22,33 is 03.
        beats.delete();
        send_byte(8'hA5);
        check("busy in LEN", 32'(busy), 1);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h03);
        repeat (5) @(negedge clk_50m);
        check("good pkt_ok count", 32'(cnt_pkt), 1);
        check("good clr count", 32'(cnt_clr), 6);
        check("good beat count", 32'(beats.size()), 3);
        check_beat(0, 8'h11, 1'b0);
        check_beat(1, 8'h22, 1'b0);
        check_beat(2, 8'h33, 1'b1);
        if (beats.size() == 3) begin
            check("first beat latency", 32'(beats[0].cyc - take_cyc), 1);
            check("beat1 consecutive", 32'(beats[1].cyc - beats[0].cyc), 1);
            check("beat2 consecutive", 32'(beats[2].cyc - beats[1].cyc), 1);
        end
        check("good busy after", 32'(busy), 0);
        check("good m_valid after", 32'(m_valid), 0);

        // Bad checksum: 02^AA^BB = 13, CHK sent as 00.
        mv_snap = cnt_mvalid;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'h00);
        repeat (2) @(negedge clk_50m);
        check("bad err_chk count", 32'(cnt_chk), 1);
        check("bad m_valid cycles", 32'(cnt_mvalid), 32'(mv_snap));
        check("bad busy", 32'(busy), 0);
        check("bad pkt_ok count", 32'(cnt_pkt), 1);

        // Following good packet: 01^5A = 5B.
        beats.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'h5B);
        repeat (3) @(negedge clk_50m);
        check("recover pkt_ok count", 32'(cnt_pkt), 2);
        check("recover beat count", 32'(beats.size()), 1);
        check_beat(0, 8'h5A, 1'b1);

        // Junk then length errors (LEN=0 and LEN=17).
        send_byte(8'h00);
        send_byte(8'hFF);
        check("junk no err_len", 32'(cnt_len), 0);
        check("junk busy", 32'(busy), 0);
        send_byte(8'hA5);
        send_byte(8'h00);
        check("len0 err_len", 32'(cnt_len), 1);
        send_byte(8'hA5);
        send_byte(8'h11);
        check("len17 err_len", 32'(cnt_len), 2);
        check("len busy", 32'(busy), 0);
        check("len no other errors", 32'(cnt_chk + cnt_tmo), 1);

        // Timeout after the first payload byte.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        repeat (15) @(negedge clk_50m);
        check("tmo count", 32'(cnt_tmo), 1);
        check("tmo latency", 32'(tmo_cyc - take_cyc), 8);
        check("tmo busy", 32'(busy), 0);
        check("clr total", 32'(cnt_clr), 24);

        // Backpressure: 02^C3^3C = FD; three bytes land while draining is stalled.
        beats.delete();
        m_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hC3);
        send_byte(8'h3C);
        send_byte(8'hFD);
        check("bp m_valid", 32'(m_valid), 1);
        check("bp m_data", 32'(m_data), 32'h C3);
        send_byte(8'hA5);
        send_byte(8'h77);
        check("bp hold data", 32'(m_data), 32'h C3);
        send_byte(8'h88);
        repeat (12) @(negedge clk_50m);
        check("bp hold data late", 32'(m_data), 32'h C3);
        check("bp hold last", 32'(m_last), 0);
        check("bp drop count", 32'(cnt_drop), 3);
        check("bp busy", 32'(busy), 1);
        check("bp no beats", 32'(beats.size()), 0);
        m_ready = 1'b1;
        repeat (4) @(negedge clk_50m);
        check("bp beat count", 32'(beats.size()), 2);
        check_beat(0, 8'hC3, 1'b0);
        check_beat(1, 8'h3C, 1'b1);
        check("bp busy after", 32'(busy), 0);
        check("bp pkt_ok count", 32'(cnt_pkt), 3);

        // Reset in the middle of a payload.
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h10);
        send_byte(8'h20);
        check("pre-reset busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("async reset outputs", all_outs(), 0);
        @(negedge clk_50m);
        @(negedge clk_50m);
        rst = 1'b0;
        @(negedge clk_50m);
        beats.delete();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h01);
        repeat (4) @(negedge clk_50m);
        check("post-reset pkt_ok count", 32'(cnt_pkt), 4);
        check("post-reset beat count", 32'(beats.size()), 2);
        check_beat(0, 8'h01, 1'b0);
        check_beat(1, 8'h02, 1'b1);
        check("final clr total", 32'(cnt_clr), 41);
        check("error exclusivity", 32'(cnt_multi), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
